data_cache: RTL
===============

Name: data_cache

Overview:
- Direct-mapped, write-back, write-allocate data cache between the pipeline's MEM-stage data port and main memory.
- The MEM stage presents word requests. The cache answers hits in the same cycle.
- On a miss it holds the requester off with cpu_ready=0 (the hazard unit stalls the pipeline) while it writes back the victim line and refills from memory.
- Memory is accessed one whole 4-word line per handshake. Hit and miss counters are exported for performance measurement.

Parameters:
- WORD_SIZE, 16, data and address width (word-addressed)
- INDEX_BITS, 2, line index width; NUM_LINES = 2^INDEX_BITS
- Fixed, not a parameter: line = 4 words, offset = addr[1:0], index = addr[INDEX_BITS+1:2], tag = remaining upper bits

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- cpu_read  in  1  MEM-stage load request
- cpu_write  in  1  MEM-stage store request
- cpu_addr  in  WORD_SIZE  word address
- cpu_wdata  in  WORD_SIZE  store data
- cpu_rdata  out  WORD_SIZE  load data, valid when cpu_ready=1
- cpu_ready  out  1  request completes this cycle
- mem_req  out  1  memory line transaction pending
- mem_we  out  1  1 = line write-back, 0 = line fill
- mem_addr  out  WORD_SIZE  line base address, low 2 bits = 0
- mem_wdata  out  4*WORD_SIZE  victim line; word k in bits [16k+15:16k]
- mem_rdata  in  4*WORD_SIZE  fill line, same packing
- mem_ack  in  1  one-cycle pulse; transaction done, mem_rdata valid this cycle for a fill
- hit_count  out  WORD_SIZE  completed accesses that hit on first lookup
- miss_count  out  WORD_SIZE  accesses that caused a refill

Behaviour:
- Request definition: req = cpu_read | cpu_write. If both are high, the request is treated as a write.
- hit = valid[index] & (tag_array[index] == tag).
- States: IDLE, WRITEBACK, FILL.
- IDLE:
  - cpu_ready = req & hit, combinational, zero added latency.
  - Read hit: cpu_rdata = addressed word.
  - Write hit: addressed word <= cpu_wdata and dirty[index] <= 1 at the clock edge.
  - Miss with dirty victim: go to WRITEBACK. Miss with clean or invalid victim: go to FILL.
  - On a miss, miss_count increments once and the replay flag is set.
- WRITEBACK:
  - mem_req=1, mem_we=1, mem_addr = {victim tag, index, 2'b00}, mem_wdata = victim line.
  - On mem_ack: dirty[index] <= 0, go to FILL.
- FILL:
  - mem_req=1, mem_we=0, mem_addr = {tag, index, 2'b00}.
  - On mem_ack: line <= mem_rdata, tag <= tag, valid <= 1, dirty <= 0, go to IDLE.
- Replay: the held request then hits in IDLE. cpu_ready=1 and the write merges as a normal write hit. hit_count does NOT increment for this replay; the replay flag clears.
- mem_req is decoded from state and stays high from WRITEBACK straight into FILL. mem_addr, mem_we and mem_wdata are stable while mem_req=1 and no ack has arrived.
- cpu_ready=0 in WRITEBACK and FILL, and in IDLE on a miss or when there is no request.
- cpu_rdata = 0 whenever cpu_ready=0 or the access is a write.
- Request dropped or changed mid-miss: the transaction in flight completes and the line is installed. The next IDLE lookup uses the current inputs. The replay flag clears on the first IDLE cycle regardless.
- hit_count increments when cpu_ready=1 and the replay flag is clear.
- Both counters saturate at 16'hFFFF and never wrap.
- mem_ack outside WRITEBACK/FILL is ignored.
- Reset, applied at any time including mid-miss:
  - state=IDLE; all valid and dirty bits = 0; counters = 0; replay flag = 0.
  - Outputs then: mem_req=0, mem_we=0, cpu_ready=0, cpu_rdata=0, mem_addr=0, mem_wdata=0.
  - Dirty data is discarded. Tag and data arrays need no reset.
- Latency, memory acking in cycle N of each transaction:
  - clean miss: cpu_ready in cycle N+1 after the request cycle;
  - dirty miss: cpu_ready in cycle 2N+1.

Test Plan:
- Reset, then read 0x0010 (memory acks in the 3rd FILL cycle with line {D,C,B,A}=0x000D_000C_000B_000A):
  - request cycle: cpu_ready=0;
  - FILL: mem_addr=0x0010, mem_we=0;
  - 4 cycles after the request: cpu_ready=1, cpu_rdata=0x000A;
  - miss_count=1, hit_count=0.
- Then read 0x0013: cpu_ready=1 in the same cycle, cpu_rdata=0x000D, hit_count=1, no mem_req.
- Write 0x1234 to 0x0011 (hit), then read 0x0050 (same index 0, different tag):
  - WRITEBACK: mem_addr=0x0010, mem_we=1, mem_wdata=0x000D_000C_1234_000A;
  - then FILL: mem_addr=0x0050;
  - miss_count +1.
- Write miss 0x00A2 with data 0xBEEF on a clean line:
  - fill, then merge; a subsequent read of 0x00A2 returns 0xBEEF as a hit;
  - a later eviction writes back 0xBEEF in word 2.
- Assert reset during FILL before mem_ack:
  - next cycle mem_req=0 and counters=0;
  - re-read 0x0010 misses again (valid cleared).
- Drive 65535 hits, then one more: hit_count stays 16'hFFFF.

Source files
------------

// File: rtl/data_cache.sv
// Direct-mapped, write-back, write-allocate data cache between the MEM-stage data port and main memory.
// Hits are answered combinationally; misses stall the requester while one 4-word line moves per memory handshake.
module data_cache #(
    parameter int unsigned WORD_SIZE  = 16,
    parameter int unsigned INDEX_BITS = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cpu_read,
    input  logic                   cpu_write,
    input  logic [WORD_SIZE-1:0]   cpu_addr,
    input  logic [WORD_SIZE-1:0]   cpu_wdata,
    output logic [WORD_SIZE-1:0]   cpu_rdata,
    output logic                   cpu_ready,
    output logic                   mem_req,
    output logic                   mem_we,
    output logic [WORD_SIZE-1:0]   mem_addr,
    output logic [4*WORD_SIZE-1:0] mem_wdata,
    input  logic [4*WORD_SIZE-1:0] mem_rdata,
    input  logic                   mem_ack,
    output logic [WORD_SIZE-1:0]   hit_count,
    output logic [WORD_SIZE-1:0]   miss_count
);

    localparam int unsigned NUM_LINES = 1 << INDEX_BITS;
    localparam int unsigned OFF_BITS  = 2;
    localparam int unsigned WORDS     = 4;
    localparam int unsigned TAG_BITS  = WORD_SIZE - INDEX_BITS - OFF_BITS;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WRITEBACK = 2'd1,
        S_FILL      = 2'd2
    } state_e;

    state_e                  state_q;
    logic [NUM_LINES-1:0]    valid_q;
    logic [NUM_LINES-1:0]    dirty_q;
    logic [TAG_BITS-1:0]     tag_q  [NUM_LINES];
    logic [WORD_SIZE-1:0]    data_q [NUM_LINES][WORDS];
    logic [TAG_BITS-1:0]     miss_tag_q;
    logic [INDEX_BITS-1:0]   miss_idx_q;
    logic                    replay_q;
    logic                    mem_req_q;
    logic                    mem_we_q;
    logic [WORD_SIZE-1:0]    mem_addr_q;
    logic [4*WORD_SIZE-1:0]  mem_wdata_q;
    logic [WORD_SIZE-1:0]    hit_count_q;
    logic [WORD_SIZE-1:0]    miss_count_q;

    logic [TAG_BITS-1:0]     req_tag;
    logic [INDEX_BITS-1:0]   req_idx;
    logic [OFF_BITS-1:0]     req_off;
    logic                    req;
    logic                    hit;
    logic                    idle;

    assign req_tag = cpu_addr[WORD_SIZE-1 -: TAG_BITS];
    assign req_idx = cpu_addr[OFF_BITS +: INDEX_BITS];
    assign req_off = cpu_addr[OFF_BITS-1:0];
    assign req     = cpu_read | cpu_write;
    assign hit     = valid_q[req_idx] & (tag_q[req_idx] == req_tag);
    assign idle    = (state_q == S_IDLE);

    // Zero-latency hit path; a store (even with cpu_read also high) returns no data.
    assign cpu_ready = idle & req & hit;
    assign cpu_rdata = (cpu_ready & ~cpu_write) ? data_q[req_idx][req_off] : '0;

    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            valid_q      <= '0;
            dirty_q      <= '0;
            miss_tag_q   <= '0;
            miss_idx_q   <= '0;
            replay_q     <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    replay_q <= 1'b0;
                    if (cpu_ready) begin
                        // The hit that completes a refilled request is not a first-lookup hit.
                        if (!replay_q && (hit_count_q != '1)) begin
                            hit_count_q <= hit_count_q + WORD_SIZE'(1);
                        end
                        if (cpu_write) begin
                            data_q[req_idx][req_off] <= cpu_wdata;
                            dirty_q[req_idx]         <= 1'b1;
                        end
                    end else if (req) begin
                        if (miss_count_q != '1) begin
                            miss_count_q <= miss_count_q + WORD_SIZE'(1);
                        end
                        replay_q   <= 1'b1;
                        miss_tag_q <= req_tag;
                        miss_idx_q <= req_idx;
                        mem_req_q  <= 1'b1;
                        if (valid_q[req_idx] && dirty_q[req_idx]) begin
                            state_q    <= S_WRITEBACK;
                            mem_we_q   <= 1'b1;
                            mem_addr_q <= {tag_q[req_idx], req_idx, 2'b00};
                            for (int k = 0; k < int'(WORDS); k++) begin
                                mem_wdata_q[k*WORD_SIZE +: WORD_SIZE] <= data_q[req_idx][k];
                            end
                        end else begin
                            state_q     <= S_FILL;
                            mem_we_q    <= 1'b0;
                            mem_addr_q  <= {req_tag, req_idx, 2'b00};
                            mem_wdata_q <= '0;
                        end
                    end
                end
                S_WRITEBACK: begin
                    if (mem_ack) begin
                        dirty_q[miss_idx_q] <= 1'b0;
                        state_q             <= S_FILL;
                        mem_we_q            <= 1'b0;
                        mem_addr_q          <= {miss_tag_q, miss_idx_q, 2'b00};
                    end
                end
                S_FILL: begin
                    if (mem_ack) begin
                        for (int k = 0; k < int'(WORDS); k++) begin
                            data_q[miss_idx_q][k] <= mem_rdata[k*WORD_SIZE +: WORD_SIZE];
                        end
                        tag_q[miss_idx_q]   <= miss_tag_q;
                        valid_q[miss_idx_q] <= 1'b1;
                        dirty_q[miss_idx_q] <= 1'b0;
                        state_q             <= S_IDLE;
                        mem_req_q           <= 1'b0;
                        mem_we_q            <= 1'b0;
                        mem_addr_q          <= '0;
                        mem_wdata_q         <= '0;
                    end
                end
                default: begin
                    state_q   <= S_IDLE;
                    mem_req_q <= 1'b0;
                    mem_we_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule
